alu_result_collector: RTL and testbench
=======================================

ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 SHALL have parameter Op_Width, default 16, the operand/result width matching the ALU datapath.
REQ-002 SHALL have parameter Depth, default 4, the result FIFO depth (power of two, >=2).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-low.
REQ-005 Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT  input  Op_Width each  registered ALU unit results.
REQ-006 Arith_FLAG, Logic_FLAG, CMP_FLAG, Shift_FLAG  input  1 each  unit-result-valid strobes.
REQ-007 Carry_OUT  input  1  arithmetic carry.
REQ-008 Out_Ready  input  1  downstream accept.
REQ-009 Err_Clr  input  1  clears sticky errors and drop counter.
REQ-010 Out_Data  output  Op_Width  head-entry result.
REQ-011 Out_Src  output  2  head-entry source: 00 arith, 01 logic, 10 cmp, 11 shift (equals ALU_FUN[3:2]).
REQ-012 Out_Carry  output  1  head-entry carry.
REQ-013 Out_Valid  output  1  head entry present.
REQ-014 Fifo_Count  output  log2(Depth)+1  occupancy.
REQ-015 Overflow_Err, Multi_Err  output  1 each  sticky error flags.
REQ-016 Drop_Cnt  output  8  saturating count of discarded results.

Function
REQ-017 Each cycle SHALL evaluate the four FLAG inputs; exactly one high = capture event, none high = idle, two or more = multi-flag event.
REQ-018 Capture SHALL form entry {Src code, Carry, Data} from the flagged unit; Carry = Carry_OUT for arith, 0 otherwise.
REQ-019 Write SHALL occur at the rising edge ending the flag cycle; Out_Valid SHALL be high in the following cycle (1-cycle latency, empty FIFO).
REQ-020 FIFO SHALL be first-word-fall-through: Out_Data/Out_Src/Out_Carry show head entry whenever Out_Valid=1; Out_Valid = (Fifo_Count != 0).
REQ-021 Pop SHALL occur on edges where Out_Valid=1 and Out_Ready=1; outputs SHALL hold stable while Out_Valid=1 and Out_Ready=0.
REQ-022 Push when full SHALL be accepted only if a pop occurs on the same edge (count stays Depth); otherwise entry discarded, Overflow_Err set, Drop_Cnt incremented.
REQ-023 Simultaneous push and pop when not full/empty SHALL leave Fifo_Count unchanged; push+pop on empty SHALL not pop (push only, count=1).
REQ-024 Multi-flag event SHALL push nothing, set Multi_Err, increment Drop_Cnt.
REQ-025 Drop_Cnt SHALL saturate at 255, never wrap.
REQ-026 Read/write pointers SHALL wrap modulo Depth; order SHALL be strictly preserved.
REQ-027 Err_Clr=1 SHALL clear Overflow_Err, Multi_Err, Drop_Cnt next edge; an error event on the same edge SHALL win (flag set, Drop_Cnt=1).
REQ-028 Out_Ready with Out_Valid=0 SHALL have no effect.

Reset
REQ-029 RST=0 at an edge SHALL set Fifo_Count=0, pointers=0, Out_Valid=0, Out_Data=0, Out_Src=0, Out_Carry=0, Overflow_Err=0, Multi_Err=0, Drop_Cnt=0; any in-flight flag that cycle is ignored.
REQ-030 Reset mid-operation SHALL discard all stored entries; capture SHALL resume the first cycle RST=1.

Verification
REQ-031 Arith_FLAG=1, Arith_OUT=16'hFFFE, Carry_OUT=1, Out_Ready=1 -> next cycle Out_Valid=1, Out_Data=FFFE, Out_Src=00, Out_Carry=1; following cycle Out_Valid=0.
REQ-032 Out_Ready=0; Logic, CMP, Shift, Arith flags on 4 consecutive cycles with data 1,2,3,4 -> Fifo_Count=4; then Shift_FLAG data 5 -> Overflow_Err=1, Drop_Cnt=1; Out_Ready=1 pops 1,2,3,4 with Src 01,10,11,00.
REQ-033 Full FIFO, Out_Ready=1 and CMP_FLAG data 9 same cycle -> Fifo_Count stays 4, no overflow, 9 emerges last.
REQ-034 Arith_FLAG and Logic_FLAG both 1 -> no push, Multi_Err=1, Drop_Cnt=1; Err_Clr=1 -> both cleared next cycle.
REQ-035 300 consecutive multi-flag cycles -> Drop_Cnt=255.
REQ-036 FIFO holding 3 entries, RST=0 for one edge -> Fifo_Count=0, Out_Valid=0, all outputs 0; next Logic_FLAG capture appears normally.

Source files
------------

// File: rtl/alu_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_collector
//  Description : Collects one-hot ALU unit results into a first-word-fall-
//                through FIFO with sticky overflow/multi-flag error tracking.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_result_collector #(
    parameter int Op_Width = 16,
    parameter int Depth    = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [Op_Width-1:0]      Arith_OUT,
    input  logic [Op_Width-1:0]      Logic_OUT,
    input  logic [Op_Width-1:0]      CMP_OUT,
    input  logic [Op_Width-1:0]      Shift_OUT,
    input  logic                     Arith_FLAG,
    input  logic                     Logic_FLAG,
    input  logic                     CMP_FLAG,
    input  logic                     Shift_FLAG,
    input  logic                     Carry_OUT,
    input  logic                     Out_Ready,
    input  logic                     Err_Clr,
    output logic [Op_Width-1:0]      Out_Data,
    output logic [1:0]               Out_Src,
    output logic                     Out_Carry,
    output logic                     Out_Valid,
    output logic [$clog2(Depth):0]   Fifo_Count,
    output logic                     Overflow_Err,
    output logic                     Multi_Err,
    output logic [7:0]               Drop_Cnt
);

    localparam int c_ptr_w   = $clog2(Depth);
    localparam int c_cnt_w   = c_ptr_w + 1;
    localparam int c_entry_w = Op_Width + 3;
    localparam logic [c_cnt_w-1:0] c_full = Depth[c_cnt_w-1:0];

    logic [c_entry_w-1:0] r_mem [Depth];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_ovf_err;
    logic                 r_multi_err;
    logic [7:0]           r_drop_cnt;

    logic [3:0]           w_flags;
    logic                 w_one_hot;
    logic                 w_multi;
    logic [c_entry_w-1:0] w_entry;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_ovf;
    logic                 w_drop;
    logic [c_entry_w-1:0] w_head;

    assign w_flags   = {Shift_FLAG, CMP_FLAG, Logic_FLAG, Arith_FLAG};
    assign w_one_hot = (w_flags != 4'd0) && ((w_flags & (w_flags - 4'd1)) == 4'd0);
    assign w_multi   = (w_flags != 4'd0) && !w_one_hot;

    // Entry layout: {src[1:0], carry, data}; carry only meaningful for arith
    always_comb begin
        w_entry = '0;
        case (w_flags)
            4'b0001: w_entry = {2'b00, Carry_OUT, Arith_OUT};
            4'b0010: w_entry = {2'b01, 1'b0,      Logic_OUT};
            4'b0100: w_entry = {2'b10, 1'b0,      CMP_OUT};
            4'b1000: w_entry = {2'b11, 1'b0,      Shift_OUT};
            default: w_entry = '0;
        endcase
    end

    assign w_full = (r_count == c_full);
    assign w_pop  = (r_count != '0) && Out_Ready;
    // A full FIFO can still accept when the head leaves on the same edge
    assign w_push = w_one_hot && (!w_full || w_pop);
    assign w_ovf  = w_one_hot && w_full && !w_pop;
    assign w_drop = w_ovf || w_multi;

    always_ff @(posedge CLK) begin
        if (RST && w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ovf_err   <= 1'b0;
            r_multi_err <= 1'b0;
            r_drop_cnt  <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // An error on the clearing edge takes precedence over the clear
            r_ovf_err   <= (r_ovf_err   && !Err_Clr) || w_ovf;
            r_multi_err <= (r_multi_err && !Err_Clr) || w_multi;
            if (Err_Clr) begin
                r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
            end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign Out_Valid    = (r_count != '0);
    assign Out_Data     = Out_Valid ? w_head[Op_Width-1:0] : '0;
    assign Out_Carry    = Out_Valid ? w_head[Op_Width]     : 1'b0;
    assign Out_Src      = Out_Valid ? w_head[Op_Width+2:Op_Width+1] : 2'b00;
    assign Fifo_Count   = r_count;
    assign Overflow_Err = r_ovf_err;
    assign Multi_Err    = r_multi_err;
    assign Drop_Cnt     = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_collector
//  Description : Directed table-driven checks of alu_result_collector.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_result_collector;

    localparam logic [3:0] c_a = 4'b0001;
    localparam logic [3:0] c_l = 4'b0010;
    localparam logic [3:0] c_c = 4'b0100;
    localparam logic [3:0] c_s = 4'b1000;
    localparam logic [3:0] c_n = 4'b0000;

    typedef struct {
        logic        rst_n;
        logic [3:0]  flg;
        logic [15:0] data;
        logic        carry;
        logic        ready;
        logic        clr;
        logic [32:0] exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
    logic        Arith_FLAG, Logic_FLAG, CMP_FLAG, Shift_FLAG;
    logic        Carry_OUT, Out_Ready, Err_Clr;
    logic [15:0] Out_Data;
    logic [1:0]  Out_Src;
    logic        Out_Carry, Out_Valid;
    logic [2:0]  Fifo_Count;
    logic        Overflow_Err, Multi_Err;
    logic [7:0]  Drop_Cnt;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t vecs[$];

    alu_result_collector #(.Op_Width(16), .Depth(4)) dut (
        .CLK(CLK), .RST(RST),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
        .Arith_FLAG(Arith_FLAG), .Logic_FLAG(Logic_FLAG), .CMP_FLAG(CMP_FLAG), .Shift_FLAG(Shift_FLAG),
        .Carry_OUT(Carry_OUT), .Out_Ready(Out_Ready), .Err_Clr(Err_Clr),
        .Out_Data(Out_Data), .Out_Src(Out_Src), .Out_Carry(Out_Carry), .Out_Valid(Out_Valid),
        .Fifo_Count(Fifo_Count), .Overflow_Err(Overflow_Err), .Multi_Err(Multi_Err),
        .Drop_Cnt(Drop_Cnt)
    );

    always #5 CLK = ~CLK;

    // exp packs {valid, data, src, carry, count, ovf, multi, drop}
    function automatic vec_t mk(logic rst_n, logic [3:0] flg, logic [15:0] data,
                                logic carry, logic ready, logic clr,
                                logic v, logic [15:0] d, logic [1:0] s, logic c,
                                logic [2:0] cnt, logic ovf, logic mul, logic [7:0] drop);
        vec_t t;
        t.rst_n = rst_n; t.flg = flg; t.data = data;
        t.carry = carry; t.ready = ready; t.clr = clr;
        t.exp = {v, d, s, c, cnt, ovf, mul, drop};
        return t;
    endfunction

    // Unflagged units carry distinct junk so a wrong source select is visible
    task automatic drive(logic rst_n, logic [3:0] flg, logic [15:0] data,
                         logic carry, logic ready, logic clr);
        RST        = rst_n;
        Arith_FLAG = flg[0]; Logic_FLAG = flg[1]; CMP_FLAG = flg[2]; Shift_FLAG = flg[3];
        Arith_OUT  = flg[0] ? data : 16'hDEA0;
        Logic_OUT  = flg[1] ? data : 16'hDEA1;
        CMP_OUT    = flg[2] ? data : 16'hDEA2;
        Shift_OUT  = flg[3] ? data : 16'hDEA3;
        Carry_OUT  = carry;
        Out_Ready  = ready;
        Err_Clr    = clr;
    endtask

    task automatic check(string name, logic [32:0] exp);
        logic [32:0] act;
        act = {Out_Valid, Out_Data, Out_Src, Out_Carry, Fifo_Count,
               Overflow_Err, Multi_Err, Drop_Cnt};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got v=%b d=%h s=%b c=%b cnt=%0d ovf=%b mul=%b drop=%0d, want v=%b d=%h s=%b c=%b cnt=%0d ovf=%b mul=%b drop=%0d",
                     name, act[32], act[31:16], act[15:14], act[13], act[12:10], act[9], act[8], act[7:0],
                     exp[32], exp[31:16], exp[15:14], exp[13], exp[12:10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic step(logic rst_n, logic [3:0] flg, logic [15:0] data,
                        logic carry, logic ready, logic clr);
        @(negedge CLK);
        drive(rst_n, flg, data, carry, ready, clr);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        drive(1'b0, c_n, 16'h0, 1'b0, 1'b0, 1'b0);
        //                rst flg   data     cy rdy clr   v  data     src   c  cnt ovf mul drop
        vecs.push_back(mk(0, c_a, 16'h1234, 1, 0, 0,   0, 16'h0000, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 1, 0,   0, 16'h0000, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, c_a, 16'hFFFE, 1, 1, 0,   1, 16'hFFFE, 2'b00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 1, 0,   0, 16'h0000, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, c_l, 16'h0001, 1, 0, 0,   1, 16'h0001, 2'b01, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, c_c, 16'h0002, 0, 0, 0,   1, 16'h0001, 2'b01, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, c_s, 16'h0003, 0, 0, 0,   1, 16'h0001, 2'b01, 0, 3, 0, 0, 0));
        vecs.push_back(mk(1, c_a, 16'h0004, 0, 0, 0,   1, 16'h0001, 2'b01, 0, 4, 0, 0, 0));
        vecs.push_back(mk(1, c_s, 16'h0005, 0, 0, 0,   1, 16'h0001, 2'b01, 0, 4, 1, 0, 1));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 1, 0,   1, 16'h0002, 2'b10, 0, 3, 1, 0, 1));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 1, 0,   1, 16'h0003, 2'b11, 0, 2, 1, 0, 1));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 1, 0,   1, 16'h0004, 2'b00, 0, 1, 1, 0, 1));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 1, 0,   0, 16'h0000, 2'b00, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 0, 1,   0, 16'h0000, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, c_a, 16'h0011, 1, 0, 0,   1, 16'h0011, 2'b00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, c_l, 16'h0022, 0, 0, 0,   1, 16'h0011, 2'b00, 1, 2, 0, 0, 0));
        vecs.push_back(mk(1, c_c, 16'h0033, 0, 0, 0,   1, 16'h0011, 2'b00, 1, 3, 0, 0, 0));
        vecs.push_back(mk(1, c_s, 16'h0044, 0, 0, 0,   1, 16'h0011, 2'b00, 1, 4, 0, 0, 0));
        vecs.push_back(mk(1, c_c, 16'h0009, 0, 1, 0,   1, 16'h0022, 2'b01, 0, 4, 0, 0, 0));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 1, 0,   1, 16'h0033, 2'b10, 0, 3, 0, 0, 0));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 1, 0,   1, 16'h0044, 2'b11, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 1, 0,   1, 16'h0009, 2'b10, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 1, 0,   0, 16'h0000, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0011, 16'h0000, 0, 0, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 0, 1,   0, 16'h0000, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1100, 16'h0000, 0, 0, 1, 0, 16'h0000, 2'b00, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 0, 1,   0, 16'h0000, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, c_l, 16'h00A1, 0, 0, 0,   1, 16'h00A1, 2'b01, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, c_c, 16'h00A2, 0, 0, 0,   1, 16'h00A1, 2'b01, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, c_s, 16'h00A3, 0, 0, 0,   1, 16'h00A1, 2'b01, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, c_a, 16'hBEEF, 1, 0, 0,   0, 16'h0000, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, c_l, 16'h005A, 0, 0, 0,   1, 16'h005A, 2'b01, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 1, 0,   0, 16'h0000, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, c_a, 16'h0077, 1, 1, 0,   1, 16'h0077, 2'b00, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, c_n, 16'h0000, 0, 1, 0,   0, 16'h0000, 2'b00, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].flg, vecs[i].data, vecs[i].carry, vecs[i].ready, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Drop counter saturation under a long run of multi-flag cycles
        for (int k = 0; k < 254; k++) step(1, 4'b0101, 16'h0, 0, 0, 0);
        check("drop_254", {1'b0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 8'd254});
        step(1, 4'b1010, 16'h0, 0, 0, 0);
        check("drop_255", {1'b0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 8'd255});
        for (int k = 0; k < 45; k++) step(1, 4'b1111, 16'h0, 0, 0, 0);
        check("drop_sat_300", {1'b0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 8'd255});

        // Ready with an empty FIFO changes nothing
        step(1, c_n, 16'h0, 0, 1, 0);
        check("ready_empty", {1'b0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 8'd255});
        step(1, c_n, 16'h0, 0, 0, 1);
        check("clr_after_sat", {1'b0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0});

        // Overflow coinciding with a clear leaves the flag set and count at 1
        for (int k = 0; k < 4; k++) step(1, c_c, 16'(16'h0100 + k), 0, 0, 0);
        check("refill_full", {1'b1, 16'h0100, 2'b10, 1'b0, 3'd4, 1'b0, 1'b0, 8'd0});
        step(1, c_a, 16'hCAFE, 1, 0, 1);
        check("ovf_with_clr", {1'b1, 16'h0100, 2'b10, 1'b0, 3'd4, 1'b1, 1'b0, 8'd1});
        for (int k = 0; k < 4; k++) begin
            step(1, c_n, 16'h0, 0, 1, 0);
            check($sformatf("drain%0d", k),
                  {(k != 3), (k != 3) ? 16'(16'h0101 + k) : 16'h0, (k != 3) ? 2'b10 : 2'b00,
                   1'b0, 3'(3 - k), 1'b1, 1'b0, 8'd1});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
